// File: rtl/counter_sched_if.sv
// Command channel for counter_sched: valid/ready handshake carrying op and
// the per-START configuration fields.
interface counter_sched_if #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [WIDTH-1:0]      cmd_period;
  logic [PRESCALE_W-1:0] cmd_prescale;
  logic                  cmd_periodic;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_period,
    output cmd_prescale,
    output cmd_periodic,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_period,
    input  cmd_prescale,
    input  cmd_periodic,
    output cmd_ready
  );

endinterface

// File: rtl/counter_sched.sv
// Command-driven sequencer for a prescaled WIDTH-bit up-counter with
// periodic or one-shot terminal-count tick.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | stopped, value=0, waiting for START
// LOAD  | one cycle: clear value and prescaler, commands not accepted
// RUN   | counting; value advances every prescale+1 cycles
// PAUSE | value and prescaler frozen until RESUME or STOP
// DONE  | one-shot finished, value held at period-1
module counter_sched #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  counter_sched_if.slave   cmd,
  output logic [WIDTH-1:0] value,
  output logic             tick,
  output logic             busy,
  output logic             err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_PAUSE  = 2'b10;
  localparam logic [1:0] OP_RESUME = 2'b11;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [WIDTH-1:0]      period_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  periodic_q;
  logic [PRESCALE_W-1:0] psc_cnt;

  logic accept;
  logic is_start;
  logic is_stop;
  logic is_pause;
  logic is_resume;
  logic start_ok;
  logic stop_ok;
  logic pause_ok;
  logic resume_ok;
  logic cmd_err;
  logic count_en;
  logic psc_hit;
  logic terminal;
  logic adv;

  assign cmd.cmd_ready = (state != ST_LOAD);
  assign busy = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_PAUSE);

  // command decode
  assign accept    = cmd.cmd_valid && cmd.cmd_ready;
  assign is_start  = accept && (cmd.cmd_op == OP_START);
  assign is_stop   = accept && (cmd.cmd_op == OP_STOP);
  assign is_pause  = accept && (cmd.cmd_op == OP_PAUSE);
  assign is_resume = accept && (cmd.cmd_op == OP_RESUME);

  assign start_ok  = is_start && ((state == ST_IDLE) || (state == ST_DONE))
                     && (cmd.cmd_period != '0);
  assign stop_ok   = is_stop && ((state == ST_RUN) || (state == ST_PAUSE)
                     || (state == ST_DONE));
  assign pause_ok  = is_pause && (state == ST_RUN);
  assign resume_ok = is_resume && (state == ST_PAUSE);

  // STOP in IDLE is a silent no-op, so it never reports an error
  assign cmd_err = (is_start && !start_ok) || (is_pause && !pause_ok)
                   || (is_resume && !resume_ok);

  // STOP and PAUSE win over the advance due in the same cycle
  assign count_en = (state == ST_RUN) && !stop_ok && !pause_ok;
  assign psc_hit  = (psc_cnt == prescale_q);
  assign terminal = (value == (period_q - WIDTH'(1)));
  assign adv      = count_en && psc_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop_ok)                               state_nxt = ST_IDLE;
        else if (pause_ok)                         state_nxt = ST_PAUSE;
        else if (adv && terminal && !periodic_q)   state_nxt = ST_DONE;
      end
      ST_PAUSE: begin
        if (stop_ok)        state_nxt = ST_IDLE;
        else if (resume_ok) state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (stop_ok)       state_nxt = ST_IDLE;
        else if (start_ok) state_nxt = ST_LOAD;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
    end else if (start_ok) begin
      period_q   <= cmd.cmd_period;
      prescale_q <= cmd.cmd_prescale;
      periodic_q <= cmd.cmd_periodic;
    end
  end

  // value never exceeds period-1; one-shot terminal simply holds it
  always_ff @(posedge clk) begin
    if (!reset) begin
      value   <= '0;
      psc_cnt <= '0;
    end else if ((state == ST_LOAD) || stop_ok) begin
      value   <= '0;
      psc_cnt <= '0;
    end else if (count_en) begin
      if (psc_hit) begin
        psc_cnt <= '0;
        if (!terminal) begin
          value <= value + WIDTH'(1);
        end else if (periodic_q) begin
          value <= '0;
        end
      end else begin
        psc_cnt <= psc_cnt + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick <= 1'b0;
      err  <= 1'b0;
    end else begin
      tick <= adv && terminal;
      err  <= cmd_err;
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched: reference model derived from elapsed
// running cycles, directed scenarios with literal expectations, random traffic.
module tb_counter_sched;

  localparam int WIDTH = 16;
  localparam int PSW   = 8;

  localparam logic [1:0] START  = 2'b00;
  localparam logic [1:0] STOP   = 2'b01;
  localparam logic [1:0] PAUSE  = 2'b10;
  localparam logic [1:0] RESUME = 2'b11;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] value;
  logic             tick;
  logic             busy;
  logic             err;

  counter_sched_if #(.WIDTH(WIDTH), .PRESCALE_W(PSW)) bus ();

  counter_sched #(.WIDTH(WIDTH), .PRESCALE_W(PSW)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (bus),
    .value (value),
    .tick  (tick),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model phases: 0 idle, 1 load, 2 run, 3 pause, 4 done
  int  m_ph = 0;
  int  m_el = 0;
  int  m_per = 0;
  int  m_psc = 0;
  bit  m_perd = 1'b0;
  int  e_value = 0;
  bit  e_tick = 1'b0;
  bit  e_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // value = completed prescale periods modulo the period, derived from how
  // many unpaused RUN cycles have elapsed since LOAD
  always @(posedge clk) begin
    int  prev;
    bit  acc;
    bit  suppress;
    int  len;
    int  k;
    if (!reset) begin
      m_ph = 0; m_el = 0; m_per = 0; m_psc = 0; m_perd = 0;
      e_value = 0; e_tick = 0; e_err = 0;
    end else begin
      prev = m_ph;
      acc = bus.cmd_valid && (m_ph != 1);
      suppress = 1'b0;
      e_tick = 0;
      e_err = 0;
      if (acc) begin
        case (bus.cmd_op)
          START: begin
            if ((m_ph == 0 || m_ph == 4) && bus.cmd_period != 0) begin
              m_per = int'(bus.cmd_period);
              m_psc = int'(bus.cmd_prescale);
              m_perd = bus.cmd_periodic;
              m_ph = 1;
            end else e_err = 1;
          end
          STOP: begin
            if (m_ph >= 2) begin
              m_ph = 0; e_value = 0; suppress = 1;
            end
          end
          PAUSE: begin
            if (m_ph == 2) begin m_ph = 3; suppress = 1; end
            else e_err = 1;
          end
          default: begin
            if (m_ph == 3) m_ph = 2;
            else e_err = 1;
          end
        endcase
      end
      if (prev == 1) begin
        m_ph = 2; m_el = 0; e_value = 0;
      end else if (prev == 2 && !suppress) begin
        m_el++;
        len = m_psc + 1;
        if (m_el % len == 0) begin
          k = m_el / len;
          if (k % m_per == 0) begin
            e_tick = 1;
            if (m_perd) e_value = 0;
            else begin e_value = m_per - 1; m_ph = 4; end
          end else e_value = k % m_per;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("value", 32'(value), 32'(e_value));
      chk("tick", 32'(tick), 32'(e_tick));
      chk("err", 32'(err), 32'(e_err));
      chk("busy", 32'(busy), 32'(m_ph >= 1 && m_ph <= 3));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(m_ph != 1));
    end
  end

  task automatic send(input logic [1:0] op, input int per, input int psc, input bit perd);
    bus.cmd_valid    = 1'b1;
    bus.cmd_op       = op;
    bus.cmd_period   = WIDTH'(per);
    bus.cmd_prescale = PSW'(psc);
    bus.cmd_periodic = perd;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b1;
    bus.cmd_op = START;
    bus.cmd_period = WIDTH'(5);
    bus.cmd_prescale = '0;
    bus.cmd_periodic = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    // reset held with a valid START present: nothing may be accepted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_value", 32'(value), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(bus.cmd_ready), 1);
    end
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // periodic period 5, prescale 0
    send(START, 5, 0, 1);
    chk("load_ready", 32'(bus.cmd_ready), 0);
    chk("load_busy", 32'(busy), 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("p5_value", 32'(value), 32'(i % 5));
      chk("p5_tick", 32'(tick), 32'(i > 0 && i % 5 == 0));
    end
    send(STOP, 0, 0, 0);

    // one-shot period 3, prescale 2
    send(START, 3, 2, 0);
    begin
      int exp_v[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2};
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        chk("os_value", 32'(value), 32'(exp_v[i]));
        chk("os_tick", 32'(tick), 32'(i == 9));
      end
    end
    chk("os_done_busy", 32'(busy), 0);
    send(STOP, 0, 0, 0);
    chk("os_stop_value", 32'(value), 0);

    // pause/resume at value 2
    send(START, 10, 0, 1);
    repeat (3) @(negedge clk);
    chk("pr_before", 32'(value), 2);
    send(PAUSE, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("pr_hold", 32'(value), 2);
      chk("pr_notick", 32'(tick), 0);
    end
    send(RESUME, 0, 0, 0);
    chk("pr_resume", 32'(value), 2);
    @(negedge clk);
    chk("pr_after", 32'(value), 3);
    send(STOP, 0, 0, 0);

    // illegal commands
    send(START, 8, 1, 1);
    repeat (3) @(negedge clk);
    send(START, 4, 0, 0);
    chk("err_start_run", 32'(err), 1);
    chk("err_start_busy", 32'(busy), 1);
    @(negedge clk);
    chk("err_pulse", 32'(err), 0);
    send(STOP, 0, 0, 0);
    send(START, 0, 0, 1);
    chk("err_period0", 32'(err), 1);
    chk("err_period0_busy", 32'(busy), 0);
    send(RESUME, 0, 0, 0);
    chk("err_resume_idle", 32'(err), 1);
    send(START, 2, 0, 0);
    repeat (4) @(negedge clk);
    send(PAUSE, 0, 0, 0);
    chk("err_pause_done", 32'(err), 1);
    chk("err_pause_done_value", 32'(value), 1);
    send(STOP, 0, 0, 0);

    // reset mid-run at value 7
    send(START, 10, 0, 1);
    repeat (8) @(negedge clk);
    chk("mr_value7", 32'(value), 7);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_value", 32'(value), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_tick", 32'(tick), 0);
    reset = 1'b1;

    // STOP on the terminal advance
    send(START, 4, 0, 1);
    repeat (4) @(negedge clk);
    chk("st_value3", 32'(value), 3);
    send(STOP, 0, 0, 0);
    chk("st_tick", 32'(tick), 0);
    chk("st_value", 32'(value), 0);
    chk("st_busy", 32'(busy), 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(399) != 0);
      bus.cmd_valid = ($urandom_range(4) == 0);
      bus.cmd_op = 2'($urandom_range(3));
      bus.cmd_period = ($urandom_range(9) == 0) ? '0 : WIDTH'($urandom_range(6, 1));
      bus.cmd_prescale = PSW'($urandom_range(3));
      bus.cmd_periodic = 1'($urandom_range(1));
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
Sequencer and controller for a WIDTH-bit up-counter. It accepts start/stop/pause/resume commands over a valid/ready handshake and latches a period, prescale and mode per start. It then drives the count value and emits a terminal-count tick. It sits between host/control logic and any block needing timed events (periodic strobes, one-shot timeouts).

Parameters:
WIDTH, 16, bit width of count value and period.
PRESCALE_W, 8, bit width of prescale divider.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept command this cycle.
cmd_op  input  2  00 START, 01 STOP, 10 PAUSE, 11 RESUME.
cmd_period  input  WIDTH  terminal period, START only; must be nonzero.
cmd_prescale  input  PRESCALE_W  value advances every cmd_prescale+1 cycles, START only.
cmd_periodic  input  1  1 periodic (auto-wrap), 0 one-shot; START only.
value  output  WIDTH  current count, registered.
tick  output  1  one-cycle pulse on terminal-count advance, registered.
busy  output  1  high in LOAD, RUN, PAUSE.
err  output  1  one-cycle pulse on illegal or rejected command.

Behaviour:
- Reset (reset==0 at posedge): state IDLE, value=0, tick=0, err=0, busy=0, cmd_ready=1, period/prescale/mode/prescale-counter regs=0. Reset in any state, including mid-RUN, takes effect at that edge.
- Handshake: a command is accepted on the cycle where cmd_valid&cmd_ready. Every accepted command completes in one cycle. cmd_ready=0 only in LOAD. No command buffering.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- START from IDLE or DONE:
  - If cmd_period!=0: latch period/prescale/periodic, then LOAD.
  - If cmd_period==0: err=1, state unchanged.
- START from RUN or PAUSE: err=1, no other effect.
- LOAD (exactly 1 cycle): value<=0, psc_cnt<=0, then RUN. Latency: RUN entered 2 edges after START acceptance.
- RUN:
  - Each cycle psc_cnt increments. When psc_cnt==prescale, psc_cnt<=0 and the value advances.
  - Non-terminal advance (value!=period-1): value<=value+1.
  - Terminal advance (value==period-1): tick<=1 on that same edge.
    - Periodic: value<=0, stay RUN.
    - One-shot: value holds at period-1, state goes to DONE.
  - period==1: periodic gives a tick every prescale+1 cycles with value stuck at 0.
  - Counter never exceeds period-1. Arithmetic is WIDTH-bit unsigned, with no wrap beyond the period.
- PAUSE: accepted in RUN goes to PAUSE. value and psc_cnt are frozen, and that cycle's advance is suppressed (no tick). In any other state: err=1.
- RESUME: accepted in PAUSE goes to RUN, and counting continues from the frozen psc_cnt/value. In any other state: err=1.
- STOP: from RUN, PAUSE or DONE goes to IDLE with value<=0, psc_cnt<=0. Any advance/tick due that cycle is suppressed. From IDLE: no-op, no err.
- Command precedence: a command accepted in RUN is evaluated before the advance logic. STOP and PAUSE suppress the advance. START in RUN gives err, and the advance proceeds normally.
- DONE: value holds at period-1, busy=0, tick=0. Only START or STOP have effect. PAUSE and RESUME give err.
- tick and err are never high for more than one consecutive cycle from the same event.

Test Plan:
1. Hold reset low 3 cycles with cmd_valid=1 -> value=0, tick=0, err=0, busy=0, cmd_ready=1 throughout. No command is accepted.
2. START period=5, prescale=0, periodic=1 -> next cycle LOAD with cmd_ready=0, busy=1. Then value 0,1,2,3,4,0,1,…. tick high on each 4->0 edge, exactly every 5 cycles.
3. START period=3, prescale=2, one-shot -> value 0,0,0,1,1,1,2,2,2. tick once, 9 cycles after RUN entry. value stays 2, state DONE, busy=0. Then STOP -> value 0, IDLE.
4. Periodic period=10, prescale=0; PAUSE when value=2, hold 10 cycles, then RESUME -> value stays 2 during the pause with no tick. value=3 one cycle after RESUME acceptance.
5. Illegal commands: START while RUN, START with period=0 from IDLE, RESUME in IDLE, PAUSE in DONE -> each gives a single-cycle err=1 with state and value unchanged. A running count continues undisturbed.
6. Boundary events:
   - reset low mid-RUN at value=7 -> next edge value=0, IDLE, tick=0.
   - STOP accepted on the cycle of a terminal advance (period=4, value=3) -> no tick, value=0, IDLE.
